// File: rtl/estimation_sequencer.sv
// rtl/estimation_sequencer.sv - handshake sequencer for conditioning, acquisition, estimation and theta stages
module estimation_sequencer #(
  parameter int N_CH    = 2,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CONTINUOUS,
  input  logic             ABORT,
  input  logic [N_CH-1:0]  ACK_CAS,
  input  logic [N_CH-1:0]  ACK_ACQ,
  input  logic             ACK_E,
  input  logic [N_CH-1:0]  ACK_THETA,
  output logic             CLEAR,
  output logic [N_CH-1:0]  START_ACQ,
  output logic             START_E,
  output logic [N_CH-1:0]  START_THETA,
  output logic [N_CH-1:0]  REG_THETA,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [2:0]       ERR_STAGE,
  output logic [CNT_W-1:0] CYCLE_CNT
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_CAS = 3'd1,
    CLR   = 3'd2,
    ACQ   = 3'd3,
    W_ACQ = 3'd4,
    W_E   = 3'd5,
    W_TH  = 3'd6,
    ERR   = 3'd7
  } state_t;

  // A wait state times out on the cycle its counter reaches TIMEOUT-1,
  // so the sequencer lands in ERR after exactly TIMEOUT cycles of waiting.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [N_CH-1:0] ALL_CH  = {N_CH{1'b1}};

  state_t           state, state_nxt;
  logic [N_CH-1:0]  ack_mask;
  logic [N_CH-1:0]  ack_sel;
  logic [TO_W-1:0]  to_cnt;
  logic             mask_full;
  logic             timed_out;
  logic             wait_nxt;

  logic             clear_q, clear_nxt;
  logic [N_CH-1:0]  start_acq_q, start_acq_nxt;
  logic             start_e_q, start_e_nxt;
  logic [N_CH-1:0]  start_th_q, start_th_nxt;
  logic [N_CH-1:0]  reg_th_q, reg_th_nxt;
  logic             done_q, done_nxt;
  logic [2:0]       err_stage_q, err_stage_nxt;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_nxt;

  // Route only the ack vector belonging to the current wait state; all others are ignored.
  always_comb begin
    ack_sel = '0;
    case (state)
      W_CAS:   ack_sel = ACK_CAS;
      W_ACQ:   ack_sel = ACK_ACQ;
      W_TH:    ack_sel = ACK_THETA;
      default: ack_sel = '0;
    endcase
  end

  // The current cycle's acks count toward completion together with the sticky mask.
  assign mask_full = &(ack_mask | ack_sel);
  assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign wait_nxt  = (state_nxt == W_CAS) || (state_nxt == W_ACQ) ||
                     (state_nxt == W_E)   || (state_nxt == W_TH);

  // Next-state and next-pulse decode; ABORT overrides everything at the end.
  always_comb begin
    state_nxt     = state;
    clear_nxt     = 1'b0;
    start_acq_nxt = '0;
    start_e_nxt   = 1'b0;
    start_th_nxt  = '0;
    reg_th_nxt    = '0;
    done_nxt      = 1'b0;
    err_stage_nxt = (state == ERR) ? err_stage_q : 3'd0;
    cycle_cnt_nxt = cycle_cnt_q;
    case (state)
      IDLE: begin
        if (ENABLE) state_nxt = W_CAS;
      end
      W_CAS: begin
        if (mask_full) begin
          state_nxt = CLR;
          clear_nxt = 1'b1;
        end else if (timed_out) begin
          state_nxt     = ERR;
          err_stage_nxt = 3'd1;
        end
      end
      CLR: begin
        state_nxt     = ACQ;
        start_acq_nxt = ALL_CH;
      end
      ACQ: begin
        state_nxt = W_ACQ;
      end
      W_ACQ: begin
        if (mask_full) begin
          state_nxt   = W_E;
          start_e_nxt = 1'b1;
        end else if (timed_out) begin
          state_nxt     = ERR;
          err_stage_nxt = 3'd2;
        end
      end
      W_E: begin
        if (ACK_E) begin
          state_nxt    = W_TH;
          start_th_nxt = ALL_CH;
        end else if (timed_out) begin
          state_nxt     = ERR;
          err_stage_nxt = 3'd3;
        end
      end
      W_TH: begin
        if (mask_full) begin
          state_nxt     = (CONTINUOUS && ENABLE) ? W_CAS : IDLE;
          reg_th_nxt    = ALL_CH;
          done_nxt      = 1'b1;
          cycle_cnt_nxt = cycle_cnt_q + CNT_W'(1);
        end else if (timed_out) begin
          state_nxt     = ERR;
          err_stage_nxt = 3'd4;
        end
      end
      ERR: begin
        if (!ENABLE) begin
          state_nxt     = IDLE;
          err_stage_nxt = 3'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (ABORT) begin
      state_nxt     = IDLE;
      clear_nxt     = 1'b0;
      start_acq_nxt = '0;
      start_e_nxt   = 1'b0;
      start_th_nxt  = '0;
      reg_th_nxt    = '0;
      done_nxt      = 1'b0;
      err_stage_nxt = 3'd0;
      cycle_cnt_nxt = cycle_cnt_q;
    end
  end

  // State register plus registered pulse/status outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      clear_q     <= 1'b0;
      start_acq_q <= '0;
      start_e_q   <= 1'b0;
      start_th_q  <= '0;
      reg_th_q    <= '0;
      done_q      <= 1'b0;
      err_stage_q <= 3'd0;
      cycle_cnt_q <= '0;
    end else begin
      state       <= state_nxt;
      clear_q     <= clear_nxt;
      start_acq_q <= start_acq_nxt;
      start_e_q   <= start_e_nxt;
      start_th_q  <= start_th_nxt;
      reg_th_q    <= reg_th_nxt;
      done_q      <= done_nxt;
      err_stage_q <= err_stage_nxt;
      cycle_cnt_q <= cycle_cnt_nxt;
    end
  end

  // Sticky ack mask and timeout counter restart whenever the state changes or leaves waiting.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ack_mask <= '0;
      to_cnt   <= '0;
    end else if ((state_nxt != state) || !wait_nxt) begin
      ack_mask <= '0;
      to_cnt   <= '0;
    end else begin
      ack_mask <= ack_mask | ack_sel;
      to_cnt   <= to_cnt + TO_W'(1);
    end
  end

  assign CLEAR       = clear_q;
  assign START_ACQ   = start_acq_q;
  assign START_E     = start_e_q;
  assign START_THETA = start_th_q;
  assign REG_THETA   = reg_th_q;
  assign DONE        = done_q;
  assign ERR_STAGE   = err_stage_q;
  assign CYCLE_CNT   = cycle_cnt_q;
  assign BUSY        = (state != IDLE) && (state != ERR);
  assign ERROR       = (state == ERR);

endmodule

// File: tb/tb_estimation_sequencer.sv
// tb/tb_estimation_sequencer.sv - directed table and sequence bench for estimation_sequencer
module tb_estimation_sequencer;

  localparam int N_CH    = 2;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 2;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             ENABLE;
  logic             CONTINUOUS;
  logic             ABORT;
  logic [N_CH-1:0]  ACK_CAS;
  logic [N_CH-1:0]  ACK_ACQ;
  logic             ACK_E;
  logic [N_CH-1:0]  ACK_THETA;
  logic             CLEAR;
  logic [N_CH-1:0]  START_ACQ;
  logic             START_E;
  logic [N_CH-1:0]  START_THETA;
  logic [N_CH-1:0]  REG_THETA;
  logic             BUSY;
  logic             DONE;
  logic             ERROR;
  logic [2:0]       ERR_STAGE;
  logic [CNT_W-1:0] CYCLE_CNT;

  int checks = 0;
  int errors = 0;

  estimation_sequencer #(
    .N_CH(N_CH), .TO_W(TO_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CONTINUOUS(CONTINUOUS), .ABORT(ABORT),
    .ACK_CAS(ACK_CAS), .ACK_ACQ(ACK_ACQ), .ACK_E(ACK_E), .ACK_THETA(ACK_THETA),
    .CLEAR(CLEAR), .START_ACQ(START_ACQ), .START_E(START_E), .START_THETA(START_THETA),
    .REG_THETA(REG_THETA), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .ERR_STAGE(ERR_STAGE), .CYCLE_CNT(CYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       en, cont, abrt;
    logic [1:0] cas, acq;
    logic       e;
    logic [1:0] th;
    logic       clr;
    logic [1:0] sacq;
    logic       se;
    logic [1:0] sth, rth;
    logic       dn, bsy, er;
    logic [2:0] stg;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic en, input logic cont, input logic abrt,
    input logic [1:0] cas, input logic [1:0] acq, input logic e, input logic [1:0] th,
    input logic clr, input logic [1:0] sacq, input logic se, input logic [1:0] sth,
    input logic [1:0] rth, input logic dn, input logic bsy, input logic er,
    input logic [2:0] stg, input logic [1:0] cnt);
    vec_t v;
    v.en = en; v.cont = cont; v.abrt = abrt;
    v.cas = cas; v.acq = acq; v.e = e; v.th = th;
    v.clr = clr; v.sacq = sacq; v.se = se; v.sth = sth; v.rth = rth;
    v.dn = dn; v.bsy = bsy; v.er = er; v.stg = stg; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic clr, input logic [1:0] sacq,
                          input logic se, input logic [1:0] sth, input logic [1:0] rth,
                          input logic dn, input logic bsy, input logic er,
                          input logic [2:0] stg, input logic [1:0] cnt);
    chk({tag, " CLEAR"}, CLEAR, clr);
    chk({tag, " START_ACQ"}, START_ACQ, sacq);
    chk({tag, " START_E"}, START_E, se);
    chk({tag, " START_THETA"}, START_THETA, sth);
    chk({tag, " REG_THETA"}, REG_THETA, rth);
    chk({tag, " DONE"}, DONE, dn);
    chk({tag, " BUSY"}, BUSY, bsy);
    chk({tag, " ERROR"}, ERROR, er);
    chk({tag, " ERR_STAGE"}, ERR_STAGE, stg);
    chk({tag, " CYCLE_CNT"}, CYCLE_CNT, cnt);
  endtask

  task automatic clear_inputs();
    ENABLE = 1'b0; CONTINUOUS = 1'b0; ABORT = 1'b0;
    ACK_CAS = '0; ACK_ACQ = '0; ACK_E = 1'b0; ACK_THETA = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear_inputs();
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // From IDLE at a falling edge: walk W_CAS, CLR, ACQ and return at the first W_ACQ cycle.
  task automatic to_w_acq(input string tag);
    ENABLE = 1'b1;
    @(negedge CLK);
    ACK_CAS = 2'b11;
    @(negedge CLK);
    ACK_CAS = '0;
    chk({tag, " CLR CLEAR"}, CLEAR, 1);
    @(negedge CLK);
    chk({tag, " ACQ START_ACQ"}, START_ACQ, 2'b11);
    @(negedge CLK);
    chk({tag, " W_ACQ BUSY"}, BUSY, 1);
  endtask

  // From the first W_ACQ cycle: complete every stage and return at the DONE cycle.
  task automatic finish_from_w_acq(input string tag, input logic [1:0] exp_cnt);
    ACK_ACQ = 2'b11;
    @(negedge CLK);
    ACK_ACQ = '0;
    chk({tag, " START_E"}, START_E, 1);
    ACK_E = 1'b1;
    @(negedge CLK);
    ACK_E = 1'b0;
    chk({tag, " START_THETA"}, START_THETA, 2'b11);
    ACK_THETA = 2'b11;
    @(negedge CLK);
    ACK_THETA = '0;
    chk({tag, " DONE"}, DONE, 1);
    chk({tag, " REG_THETA"}, REG_THETA, 2'b11);
    chk({tag, " CYCLE_CNT"}, CYCLE_CNT, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    RESET = 1'b1;
    #1 RESET = 1'b0;
    #2 chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    //          en cont ab cas acq  e  th | clr sacq se sth rth dn bsy er stg cnt
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // IDLE
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // W_CAS k0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // W_CAS k3 ack
    vecs.push_back(mk(1, 0, 0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // CLR, stray ack
    vecs.push_back(mk(1, 0, 0, 0, 3, 0, 0,  0, 3, 0, 0, 0, 0, 1, 0, 0, 0)); // ACQ, stray ack
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // W_ACQ k0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // W_ACQ k3 ack
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0)); // W_E k0, stray theta
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // W_E k3 ack
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 0, 1, 0, 0, 0)); // W_TH k0, ENABLE drops
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // W_TH k3 ack
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 1, 0, 0, 0, 1)); // IDLE, DONE
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // IDLE holds

    for (int i = 0; i < vecs.size(); i++) begin
      chk_outs($sformatf("vec%0d", i), vecs[i].clr, vecs[i].sacq, vecs[i].se, vecs[i].sth,
               vecs[i].rth, vecs[i].dn, vecs[i].bsy, vecs[i].er, vecs[i].stg, vecs[i].cnt);
      ENABLE = vecs[i].en; CONTINUOUS = vecs[i].cont; ABORT = vecs[i].abrt;
      ACK_CAS = vecs[i].cas; ACK_ACQ = vecs[i].acq; ACK_E = vecs[i].e; ACK_THETA = vecs[i].th;
      @(negedge CLK);
    end

    // Staggered acquisition acks: START_E only after the second half arrives.
    do_reset();
    to_w_acq("stag");
    ENABLE = 1'b0;
    ACK_ACQ = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      chk($sformatf("stag START_E t+%0d", k), START_E, 0);
      if (k == 1) ACK_ACQ = '0;
      if (k == 5) ACK_ACQ = 2'b10;
    end
    @(negedge CLK);
    ACK_ACQ = '0;
    chk("stag START_E t+6", START_E, 1);
    @(negedge CLK);
    chk("stag START_E t+7", START_E, 0);
    ACK_E = 1'b1;
    @(negedge CLK);
    ACK_E = 1'b0;
    ACK_THETA = 2'b01;
    @(negedge CLK);
    ACK_THETA = 2'b10;
    @(negedge CLK);
    ACK_THETA = '0;
    chk("stag DONE", DONE, 1);
    chk("stag CYCLE_CNT", CYCLE_CNT, 1);

    // Completion on the final timeout cycle wins, then a real timeout in W_E.
    do_reset();
    to_w_acq("tmo");
    for (int k = 1; k <= 19; k++) @(negedge CLK);
    ACK_ACQ = 2'b11;
    @(negedge CLK);
    ACK_ACQ = '0;
    chk("tmo edge START_E", START_E, 1);
    chk("tmo edge ERROR", ERROR, 0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge CLK);
      chk($sformatf("tmo W_E k%0d ERROR", k), ERROR, 0);
    end
    @(negedge CLK);
    chk_outs("tmo ERR", 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    @(negedge CLK);
    chk("tmo ERR hold", ERROR, 1);
    ENABLE = 1'b0;
    @(negedge CLK);
    chk_outs("tmo exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Continuous mode: W_CAS re-entered without IDLE, counter wraps at 4.
    do_reset();
    CONTINUOUS = 1'b1;
    ENABLE = 1'b1;
    @(negedge CLK);
    for (int s = 0; s < 4; s++) begin
      ACK_CAS = 2'b11;
      @(negedge CLK);
      ACK_CAS = '0;
      @(negedge CLK);
      @(negedge CLK);
      ACK_ACQ = 2'b11;
      @(negedge CLK);
      ACK_ACQ = '0;
      ACK_E = 1'b1;
      @(negedge CLK);
      ACK_E = 1'b0;
      ACK_THETA = 2'b11;
      @(negedge CLK);
      ACK_THETA = '0;
      chk($sformatf("cont%0d DONE", s), DONE, 1);
      chk($sformatf("cont%0d BUSY", s), BUSY, 1);
      chk($sformatf("cont%0d CYCLE_CNT", s), CYCLE_CNT, (s + 1) % 4);
    end
    CONTINUOUS = 1'b0;
    ENABLE = 1'b0;
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("cont abort BUSY", BUSY, 0);
    chk("cont abort CYCLE_CNT", CYCLE_CNT, 0);

    // ABORT together with the last theta ack: no completion.
    do_reset();
    to_w_acq("abt");
    ENABLE = 1'b0;
    ACK_ACQ = 2'b11;
    @(negedge CLK);
    ACK_ACQ = '0;
    ACK_E = 1'b1;
    @(negedge CLK);
    ACK_E = 1'b0;
    ACK_THETA = 2'b01;
    @(negedge CLK);
    ACK_THETA = 2'b10;
    ABORT = 1'b1;
    @(negedge CLK);
    ACK_THETA = '0;
    ABORT = 1'b0;
    chk_outs("abt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("abt later DONE", DONE, 0);
    chk("abt later BUSY", BUSY, 0);

    // ABORT drops a partial CAS mask; a lone second half then times out in W_CAS.
    do_reset();
    ENABLE = 1'b1;
    @(negedge CLK);
    ACK_CAS = 2'b01;
    @(negedge CLK);
    ACK_CAS = '0;
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("mask abort BUSY", BUSY, 0);
    @(negedge CLK);
    ENABLE = 1'b0;
    ACK_CAS = 2'b10;
    @(negedge CLK);
    ACK_CAS = '0;
    chk("mask no CLEAR", CLEAR, 0);
    chk("mask still BUSY", BUSY, 1);
    for (int k = 2; k <= 19; k++) @(negedge CLK);
    @(negedge CLK);
    chk_outs("cas tmo", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge CLK);
    chk_outs("cas tmo exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of W_ACQ, then a clean restart.
    do_reset();
    to_w_acq("ar1");
    finish_from_w_acq("ar1", 1);
    to_w_acq("ar2");
    #2 RESET = 1'b0;
    #1 chk_outs("async rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET = 1'b1;
    chk_outs("rst release", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_w_acq("ar3");
    ENABLE = 1'b0;
    finish_from_w_acq("ar3", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/estimation_sequencer.md
ESTIMATION_SEQUENCER -- requirements
Module: estimation_sequencer

Interface
REQ-001 Parameter N_CH, default 2: number of acquisition/theta channels (1..8).
REQ-002 Parameter TO_W, default 16: timeout counter width.
REQ-003 Parameter TIMEOUT, default 1000: max cycles per wait state; 0 disables timeout.
REQ-004 Parameter CNT_W, default 16: completed-cycle counter width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 CLK  in  1  system clock, rising edge.
REQ-007 RESET  in  1  asynchronous active-low reset.
REQ-008 ENABLE  in  1  level; permits starting a sequence.
REQ-009 CONTINUOUS  in  1  level; 1 = restart after DONE, 0 = single shot.
REQ-010 ABORT  in  1  synchronous abort, any state.
REQ-011 ACK_CAS  in  N_CH  per-channel conditioning-ready acks.
REQ-012 ACK_ACQ  in  N_CH  per-channel acquisition-done acks.
REQ-013 ACK_E  in  1  estimator-done ack.
REQ-014 ACK_THETA  in  N_CH  per-channel theta-done acks.
REQ-015 CLEAR  out  1  datapath clear pulse.
REQ-016 START_ACQ  out  N_CH  acquisition start pulses.
REQ-017 START_E  out  1  estimator start pulse.
REQ-018 START_THETA  out  N_CH  theta start pulses.
REQ-019 REG_THETA  out  N_CH  theta register-load pulses.
REQ-020 BUSY  out  1  high in every state except IDLE and ERR.
REQ-021 DONE  out  1  one-cycle pulse at sequence completion.
REQ-022 ERROR  out  1  high while in ERR.
REQ-023 ERR_STAGE  out  3  wait state that timed out (1 CAS, 2 ACQ, 3 E, 4 THETA, 0 none).
REQ-024 CYCLE_CNT  out  CNT_W  count of completed sequences.

Function
REQ-025 All pulse outputs SHALL be registered, exactly one cycle wide, all bits of a vector asserted together.
REQ-026 States SHALL be IDLE, W_CAS, CLR, ACQ, W_ACQ, W_E, W_TH, ERR.
REQ-027 IDLE: ENABLE=1 -> W_CAS next cycle.
REQ-028 W_CAS/W_ACQ/W_TH SHALL OR incoming ACK bits into a sticky mask cleared on entry; exit when mask is all ones (acks need not be simultaneous).
REQ-029 W_CAS complete -> CLR; CLR asserts CLEAR for its one cycle -> ACQ; ACQ asserts START_ACQ for its one cycle -> W_ACQ.
REQ-030 W_ACQ complete -> W_E with START_E asserted in the first W_E cycle.
REQ-031 W_E with ACK_E=1 -> W_TH with START_THETA asserted in the first W_TH cycle.
REQ-032 W_TH complete -> REG_THETA and DONE asserted next cycle, CYCLE_CNT incremented (wraps at 2^CNT_W), state -> W_CAS if CONTINUOUS=1 and ENABLE=1, else IDLE.
REQ-033 ACKs arriving outside their wait state SHALL be ignored.
REQ-034 Timeout counter SHALL clear on entry to each wait state and increment each cycle in it; reaching TIMEOUT without completion -> ERR, ERR_STAGE set.
REQ-035 Completion and timeout in the same cycle: completion wins.
REQ-036 ERR: no pulses; exit to IDLE only when ENABLE=0; ERR_STAGE cleared on exit.
REQ-037 ABORT=1 SHALL force IDLE next cycle from any state, suppress all pulses that cycle, clear sticky mask and timeout counter; ABORT has priority over completion and timeout; CYCLE_CNT unchanged.
REQ-038 Deasserting ENABLE mid-sequence SHALL not stop the sequence; it only prevents restart.

Reset
REQ-039 RESET=0 SHALL immediately force IDLE, all pulse outputs 0, BUSY=0, ERROR=0, ERR_STAGE=0, CYCLE_CNT=0, sticky mask and timeout counter 0.
REQ-040 Reset release SHALL take effect on the next rising CLK edge; no pulses in the first cycle.

Verification
REQ-041 N_CH=2, ENABLE=1, CONTINUOUS=0, ACK_CAS=11, ACK_ACQ=11, ACK_E, ACK_THETA=11 each after 3 cycles -> CLEAR, START_ACQ=11, START_E, START_THETA=11, REG_THETA=11 each once, DONE once, CYCLE_CNT=1, IDLE.
REQ-042 ACK_ACQ=01 at cycle t, 10 at t+5 -> START_E exactly once at t+6.
REQ-043 TIMEOUT=20, ACK_E never asserted -> ERROR=1, ERR_STAGE=3 after 20 cycles in W_E; ENABLE=0 -> IDLE, ERR_STAGE=0.
REQ-044 CONTINUOUS=1, three full sequences -> CYCLE_CNT=3, W_CAS re-entered without IDLE; CNT_W=2 after 4 sequences -> CYCLE_CNT=0.
REQ-045 ABORT in W_TH in the same cycle as last ACK_THETA -> no REG_THETA, no DONE, IDLE, CYCLE_CNT unchanged.
REQ-046 RESET low mid-W_ACQ -> all outputs reset values asynchronously; restart proceeds from IDLE.
